// File: rtl/fx3_pkg.sv
// fx3_pkg: constants shared by the FX3 slave-FIFO responder.
//   ADDR_RD / ADDR_WR : socket addresses as seen on the addr bus
//   DQ_W              : data bus width
//   FLAG_*            : bit positions of FLAGA..FLAGD inside the flag register
//   FLAG_RESET        : flag register value while reset is held
package fx3_pkg;

  localparam logic [1:0] ADDR_RD = 2'b11;
  localparam logic [1:0] ADDR_WR = 2'b00;
  localparam int         DQ_W    = 32;

  localparam int FLAG_A = 0;   // write socket not full
  localparam int FLAG_B = 1;   // write socket free slots above watermark
  localparam int FLAG_C = 2;   // read socket not empty
  localparam int FLAG_D = 3;   // read socket fill above watermark

  // Both buffers are empty in reset: write-side flags high, read-side low.
  localparam logic [3:0] FLAG_RESET = 4'b0011;

endpackage

// File: rtl/fx3_sock_fifo.sv
// fx3_sock_fifo: synchronous show-ahead FIFO used for one FX3 socket buffer.
//   clk_100, reset_  : clock, asynchronous active-low reset
//   push, push_data  : write request and word (ignored while full)
//   pop              : read request (ignored while empty)
//   mark_last        : set the top bit of the most recently written word
//   head             : word at the read pointer (valid while !empty)
//   count            : current occupancy
//   count_next       : occupancy after the current edge
//   full, empty      : occupancy status
module fx3_sock_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk_100,
  input  logic                       reset_,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       mark_last,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_next,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  assign count_next = count_reg + {{(CW-1){1'b0}}, do_push}
                                - {{(CW-1){1'b0}}, do_pop};

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clk_100) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end else if (mark_last && !empty) begin
      mem[wr_ptr_reg - AW'(1)][W-1] <= 1'b1;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/fx3_slave_fifo_responder.sv
// fx3_slave_fifo_responder: device-side model of the FX3 synchronous 32-bit
// slave FIFO.
//   Bus side   : slcs_n, addr, slrd_n, slwr_n, sloe_n, pktend_n, dq_i in;
//                dq_o, dq_oe, flaga..flagd out
//   Host side  : h2f_data/h2f_valid/h2f_ready fill the read socket (addr 3);
//                f2h_data/f2h_last/f2h_valid/f2h_ready drain the write
//                socket (addr 0)
//   Status     : rd_underflow, wr_overflow (sticky until reset)
module fx3_slave_fifo_responder
  import fx3_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 2,
  parameter int RD_WM  = 4,
  parameter int WR_WM  = 4
) (
  input  logic            clk_100,
  input  logic            reset_,
  input  logic            slcs_n,
  input  logic [1:0]      addr,
  input  logic            slrd_n,
  input  logic            slwr_n,
  input  logic            sloe_n,
  input  logic            pktend_n,
  input  logic [DQ_W-1:0] dq_i,
  output logic [DQ_W-1:0] dq_o,
  output logic            dq_oe,
  output logic            flaga,
  output logic            flagb,
  output logic            flagc,
  output logic            flagd,
  input  logic [DQ_W-1:0] h2f_data,
  input  logic            h2f_valid,
  output logic            h2f_ready,
  output logic [DQ_W-1:0] f2h_data,
  output logic            f2h_last,
  output logic            f2h_valid,
  input  logic            f2h_ready,
  output logic            rd_underflow,
  output logic            wr_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Strobe decode
  logic rd_sel, wr_sel, rd_hit, wr_hit, zlp_hit;
  assign rd_sel  = ~slcs_n & (addr == ADDR_RD);
  assign wr_sel  = ~slcs_n & (addr == ADDR_WR);
  assign rd_hit  = rd_sel & ~slrd_n;
  assign wr_hit  = wr_sel & ~slwr_n;
  assign zlp_hit = wr_sel & slwr_n & ~pktend_n;
  assign dq_oe   = rd_sel & ~sloe_n;

  // Read socket: host pushes, bus pops
  logic [DQ_W-1:0] rd_head;
  logic [CW-1:0]   rd_count, rd_count_next;
  logic            rd_full, rd_empty, rd_pop;

  assign rd_pop    = rd_hit & ~rd_empty;
  assign h2f_ready = ~rd_full;

  fx3_sock_fifo #(.W(DQ_W), .DEPTH(DEPTH)) u_rd_sock (
    .clk_100    (clk_100),
    .reset_     (reset_),
    .push       (h2f_valid),
    .push_data  (h2f_data),
    .pop        (rd_pop),
    .mark_last  (1'b0),
    .head       (rd_head),
    .count      (rd_count),
    .count_next (rd_count_next),
    .full       (rd_full),
    .empty      (rd_empty)
  );

  // Write socket: bus pushes {last, data}, host pops
  logic [DQ_W:0] wr_head;
  logic [CW-1:0] wr_count, wr_count_next;
  logic          wr_full, wr_empty;

  assign f2h_data  = wr_head[DQ_W-1:0];
  assign f2h_last  = wr_head[DQ_W];
  assign f2h_valid = ~wr_empty;

  fx3_sock_fifo #(.W(DQ_W + 1), .DEPTH(DEPTH)) u_wr_sock (
    .clk_100    (clk_100),
    .reset_     (reset_),
    .push       (wr_hit),
    .push_data  ({~pktend_n, dq_i}),
    .pop        (f2h_ready),
    .mark_last  (zlp_hit),
    .head       (wr_head),
    .count      (wr_count),
    .count_next (wr_count_next),
    .full       (wr_full),
    .empty      (wr_empty)
  );

  // Read latency pipeline: the popped word is captured at the pop edge and
  // reaches dq_o RD_LAT edges later; dq_o holds when no word arrives.
  logic [DQ_W-1:0] pipe_data_reg [RD_LAT];
  logic [RD_LAT-1:0] pipe_vld_reg;
  logic [DQ_W-1:0] dq_o_reg;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < RD_LAT; i++) pipe_data_reg[i] <= '0;
      pipe_vld_reg <= '0;
      dq_o_reg     <= '0;
    end else begin
      pipe_data_reg[0] <= rd_head;
      pipe_vld_reg[0]  <= rd_pop;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_data_reg[i] <= pipe_data_reg[i-1];
        pipe_vld_reg[i]  <= pipe_vld_reg[i-1];
      end
      if (pipe_vld_reg[RD_LAT-1]) dq_o_reg <= pipe_data_reg[RD_LAT-1];
    end
  end

  assign dq_o = dq_o_reg;

  // Flags follow post-edge occupancy so they never lag an operation.
  logic [3:0]    flag_reg;
  logic [3:0]    flag_next;
  logic [CW-1:0] wr_free_next;

  assign wr_free_next = CW'(DEPTH) - wr_count_next;

  always_comb begin
    flag_next         = '0;
    flag_next[FLAG_A] = (wr_count_next < CW'(DEPTH));
    flag_next[FLAG_B] = (wr_free_next > CW'(WR_WM));
    flag_next[FLAG_C] = (rd_count_next != '0);
    flag_next[FLAG_D] = (rd_count_next > CW'(RD_WM));
  end

  logic rd_underflow_reg, wr_overflow_reg;

  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      flag_reg         <= FLAG_RESET;
      rd_underflow_reg <= 1'b0;
      wr_overflow_reg  <= 1'b0;
    end else begin
      flag_reg <= flag_next;
      if (rd_hit && rd_empty) rd_underflow_reg <= 1'b1;
      if (wr_hit && wr_full)  wr_overflow_reg  <= 1'b1;
    end
  end

  assign flaga        = flag_reg[FLAG_A];
  assign flagb        = flag_reg[FLAG_B];
  assign flagc        = flag_reg[FLAG_C];
  assign flagd        = flag_reg[FLAG_D];
  assign rd_underflow = rd_underflow_reg;
  assign wr_overflow  = wr_overflow_reg;

  // Occupancy counts are only needed through count_next for the flags.
  logic unused_counts;
  assign unused_counts = ^{rd_count, wr_count};

endmodule

// File: tb/tb_fx3_slave_fifo_responder.sv
// tb_fx3_slave_fifo_responder: directed bench for the FX3 slave-FIFO
// responder. Inputs change 1 ns after a rising edge; outputs are sampled
// at the same point, so they show the effect of the preceding edge.
module tb_fx3_slave_fifo_responder;

  logic        clk_100 = 1'b0;
  logic        reset_;
  logic        slcs_n, slrd_n, slwr_n, sloe_n, pktend_n;
  logic [1:0]  addr;
  logic [31:0] dq_i, dq_o, h2f_data, f2h_data;
  logic        dq_oe, flaga, flagb, flagc, flagd;
  logic        h2f_valid, h2f_ready, f2h_last, f2h_valid, f2h_ready;
  logic        rd_underflow, wr_overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk_100 = ~clk_100;

  fx3_slave_fifo_responder dut (
    .clk_100      (clk_100),
    .reset_       (reset_),
    .slcs_n       (slcs_n),
    .addr         (addr),
    .slrd_n       (slrd_n),
    .slwr_n       (slwr_n),
    .sloe_n       (sloe_n),
    .pktend_n     (pktend_n),
    .dq_i         (dq_i),
    .dq_o         (dq_o),
    .dq_oe        (dq_oe),
    .flaga        (flaga),
    .flagb        (flagb),
    .flagc        (flagc),
    .flagd        (flagd),
    .h2f_data     (h2f_data),
    .h2f_valid    (h2f_valid),
    .h2f_ready    (h2f_ready),
    .f2h_data     (f2h_data),
    .f2h_last     (f2h_last),
    .f2h_valid    (f2h_valid),
    .f2h_ready    (f2h_ready),
    .rd_underflow (rd_underflow),
    .wr_overflow  (wr_overflow)
  );

  task automatic tick();
    @(posedge clk_100);
    #1;
  endtask

  task automatic bus_idle();
    slcs_n = 1'b1; addr = 2'b00; slrd_n = 1'b1; slwr_n = 1'b1;
    sloe_n = 1'b1; pktend_n = 1'b1; dq_i = '0;
  endtask

  task automatic test_reset();
    bus_idle();
    h2f_valid = 1'b0; h2f_data = '0; f2h_ready = 1'b0;
    reset_ = 1'b0;
    repeat (3) tick();
    reset_ = 1'b1;
    tick();
    vec_cnt++;
    if ({flaga, flagb, flagc, flagd} !== 4'b1100) begin
      $display("FAIL reset_flags: got %b want 1100", {flaga, flagb, flagc, flagd});
      err_cnt++;
    end
    vec_cnt++;
    if (dq_o !== 32'h0 || h2f_ready !== 1'b1 || f2h_valid !== 1'b0 || dq_oe !== 1'b0) begin
      $display("FAIL reset_outputs: got dq_o=%h h2f_ready=%b f2h_valid=%b dq_oe=%b want 0 1 0 0",
               dq_o, h2f_ready, f2h_valid, dq_oe);
      err_cnt++;
    end
    vec_cnt++;
    if (rd_underflow !== 1'b0 || wr_overflow !== 1'b0) begin
      $display("FAIL reset_sticky: got %b%b want 00", rd_underflow, wr_overflow);
      err_cnt++;
    end
    $display("reset: flags=%b dq_o=%h", {flaga, flagb, flagc, flagd}, dq_o);
  endtask

  task automatic test_host_fill();
    for (int i = 0; i < 16; i++) begin
      h2f_data  = 32'h100 + i;
      h2f_valid = 1'b1;
      tick();
      vec_cnt++;
      if (h2f_ready !== (i < 15) || flagc !== 1'b1 || flagd !== (i >= 4)) begin
        $display("FAIL host_fill[%0d]: got ready=%b flagc=%b flagd=%b want %b 1 %b",
                 i, h2f_ready, flagc, flagd, (i < 15), (i >= 4));
        err_cnt++;
      end
      $display("host push %h: ready=%b flagd=%b", h2f_data, h2f_ready, flagd);
    end
    h2f_valid = 1'b0;
  endtask

  task automatic test_read_burst();
    logic [31:0] exp_dq;
    slcs_n = 1'b0; addr = 2'b11; sloe_n = 1'b0;
    #1;
    vec_cnt++;
    if (dq_oe !== 1'b1) begin
      $display("FAIL read_oe_on: got %b want 1", dq_oe);
      err_cnt++;
    end
    // Reads at edges 0..16; the 17th (edge 16) finds the socket empty.
    for (int j = 0; j <= 18; j++) begin
      slrd_n = (j <= 16) ? 1'b0 : 1'b1;
      tick();
      exp_dq = (j < 2) ? 32'h0 : (j <= 17) ? 32'h100 + (j - 2) : 32'h10F;
      vec_cnt++;
      if (dq_o !== exp_dq || flagc !== (j < 15) || flagd !== (j < 11) ||
          rd_underflow !== (j >= 16)) begin
        $display("FAIL read_burst[%0d]: got dq=%h c=%b d=%b uf=%b want %h %b %b %b",
                 j, dq_o, flagc, flagd, rd_underflow, exp_dq, (j < 15), (j < 11), (j >= 16));
        err_cnt++;
      end
      $display("read edge %0d: dq_o=%h flagc=%b flagd=%b uf=%b", j, dq_o, flagc, flagd, rd_underflow);
    end
    bus_idle();
    #1;
    vec_cnt++;
    if (dq_oe !== 1'b0) begin
      $display("FAIL read_oe_off: got %b want 0", dq_oe);
      err_cnt++;
    end
  endtask

  task automatic test_write_packet();
    // Write strobe with an unselected address must not push anything.
    slcs_n = 1'b0; addr = 2'b10; slwr_n = 1'b0; dq_i = 32'h55;
    tick();
    slcs_n = 1'b1; addr = 2'b00; dq_i = 32'h66;
    tick();
    vec_cnt++;
    if (f2h_valid !== 1'b0) begin
      $display("FAIL unselected_write: got f2h_valid=%b want 0", f2h_valid);
      err_cnt++;
    end
    slcs_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dq_i = 32'hA0 + i; slwr_n = 1'b0; pktend_n = (i == 5) ? 1'b0 : 1'b1;
      tick();
      vec_cnt++;
      if (flaga !== 1'b1 || flagb !== 1'b1 || f2h_valid !== 1'b1) begin
        $display("FAIL write_pkt[%0d]: got a=%b b=%b valid=%b want 1 1 1", i, flaga, flagb, f2h_valid);
        err_cnt++;
      end
      $display("bus write %h pktend=%b", dq_i, ~pktend_n);
    end
    bus_idle();
    f2h_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vec_cnt++;
      if (f2h_valid !== 1'b1 || f2h_data !== 32'hA0 + i || f2h_last !== (i == 5)) begin
        $display("FAIL drain_pkt[%0d]: got v=%b d=%h l=%b want 1 %h %b",
                 i, f2h_valid, f2h_data, f2h_last, 32'hA0 + i, (i == 5));
        err_cnt++;
      end
      $display("host drain %h last=%b", f2h_data, f2h_last);
      tick();
    end
    f2h_ready = 1'b0;
    vec_cnt++;
    if (f2h_valid !== 1'b0) begin
      $display("FAIL drain_pkt_empty: got f2h_valid=%b want 0", f2h_valid);
      err_cnt++;
    end
  endtask

  task automatic test_zlp();
    // Zero-length packet end on an empty socket is ignored.
    slcs_n = 1'b0; addr = 2'b00; pktend_n = 1'b0;
    tick();
    vec_cnt++;
    if (f2h_valid !== 1'b0) begin
      $display("FAIL zlp_empty: got f2h_valid=%b want 0", f2h_valid);
      err_cnt++;
    end
    pktend_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dq_i = 32'hB0 + i; slwr_n = 1'b0;
      tick();
    end
    slwr_n = 1'b1; pktend_n = 1'b0;
    tick();
    bus_idle();
    f2h_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vec_cnt++;
      if (f2h_valid !== 1'b1 || f2h_data !== 32'hB0 + i || f2h_last !== (i == 1)) begin
        $display("FAIL zlp_drain[%0d]: got v=%b d=%h l=%b want 1 %h %b",
                 i, f2h_valid, f2h_data, f2h_last, 32'hB0 + i, (i == 1));
        err_cnt++;
      end
      $display("zlp drain %h last=%b", f2h_data, f2h_last);
      tick();
    end
    f2h_ready = 1'b0;
  endtask

  task automatic test_overflow();
    slcs_n = 1'b0; addr = 2'b00;
    for (int i = 0; i < 16; i++) begin
      dq_i = 32'hC00 + i; slwr_n = 1'b0;
      tick();
      vec_cnt++;
      if (flaga !== (i < 15) || flagb !== (i < 11) || wr_overflow !== 1'b0) begin
        $display("FAIL fill[%0d]: got a=%b b=%b of=%b want %b %b 0",
                 i, flaga, flagb, wr_overflow, (i < 15), (i < 11));
        err_cnt++;
      end
      $display("fill write %h: flaga=%b flagb=%b", dq_i, flaga, flagb);
    end
    dq_i = 32'hDEAD;
    tick();
    vec_cnt++;
    if (wr_overflow !== 1'b1 || flaga !== 1'b0) begin
      $display("FAIL overflow: got of=%b flaga=%b want 1 0", wr_overflow, flaga);
      err_cnt++;
    end
    $display("overflow write dead: wr_overflow=%b", wr_overflow);
    bus_idle();
    f2h_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++;
      if (f2h_valid !== 1'b1 || f2h_data !== 32'hC00 + i) begin
        $display("FAIL ovf_drain[%0d]: got v=%b d=%h want 1 %h", i, f2h_valid, f2h_data, 32'hC00 + i);
        err_cnt++;
      end
      tick();
    end
    vec_cnt++;
    if (f2h_valid !== 1'b0) begin
      $display("FAIL ovf_drain_empty: got f2h_valid=%b want 0", f2h_valid);
      err_cnt++;
    end
    $display("overflow drain done: f2h_valid=%b", f2h_valid);
    f2h_ready = 1'b0;
    // Refill a few words, pull one, then reset mid-drain.
    slcs_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dq_i = 32'hE0 + i; slwr_n = 1'b0;
      tick();
    end
    bus_idle();
    f2h_ready = 1'b1;
    tick();
    #2;
    reset_ = 1'b0;
    #1;
    vec_cnt++;
    if (f2h_valid !== 1'b0 || wr_overflow !== 1'b0 || flaga !== 1'b1 || flagb !== 1'b1) begin
      $display("FAIL reset_mid_drain: got v=%b of=%b a=%b b=%b want 0 0 1 1",
               f2h_valid, wr_overflow, flaga, flagb);
      err_cnt++;
    end
    $display("reset mid-drain: f2h_valid=%b", f2h_valid);
    f2h_ready = 1'b0;
    tick();
    reset_ = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_dq;
    for (int i = 0; i < 2; i++) begin
      h2f_data = 32'h200 + i; h2f_valid = 1'b1;
      tick();
    end
    slcs_n = 1'b0; addr = 2'b11; sloe_n = 1'b0;
    // Edges 0..2 push and pop together; edges 3..4 only pop.
    for (int j = 0; j <= 6; j++) begin
      h2f_valid = (j < 3);
      h2f_data  = 32'h202 + j;
      slrd_n    = (j < 5) ? 1'b0 : 1'b1;
      tick();
      exp_dq = (j < 2) ? 32'h0 : 32'h200 + (j - 2);
      vec_cnt++;
      if (dq_o !== exp_dq || flagc !== (j < 4) || rd_underflow !== 1'b0) begin
        $display("FAIL b2b[%0d]: got dq=%h c=%b uf=%b want %h %b 0",
                 j, dq_o, flagc, rd_underflow, exp_dq, (j < 4));
        err_cnt++;
      end
      $display("b2b edge %0d: dq_o=%h flagc=%b", j, dq_o, flagc);
    end
    h2f_valid = 1'b0;
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_host_fill();
    test_read_burst();
    test_write_packet();
    test_zlp();
    test_overflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
